// File: rtl/hazard_unit_id_pkg.sv
// Shared definitions for the ID-stage hazard unit: FSM encoding and default constants.
package hazard_unit_id_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    localparam int unsigned REG_ZERO     = 0;
    localparam int unsigned DEF_NB_DRAIN = 3;

endpackage

// File: rtl/hazard_unit_id_detect.sv
// Combinational hazard detector: flags hazards in ID that forwarding cannot resolve.
module hazard_detect_id
    import hazard_unit_id_pkg::*;
#(
    parameter int unsigned NB_ADDR = 5
) (
    input  logic [NB_ADDR-1:0] i_rs_id,
    input  logic [NB_ADDR-1:0] i_rt_id,
    input  logic               i_uses_rt_id,
    input  logic               i_branch_id,
    input  logic [NB_ADDR-1:0] i_rd_id_ex,
    input  logic               i_regWrite_id_ex,
    input  logic               i_memRead_id_ex,
    input  logic [NB_ADDR-1:0] i_rd_ex_m,
    input  logic               i_memRead_ex_m,
    output logic               o_stall
);

    logic match_ex;
    logic match_mem;

    // Register zero is hardwired, so a write to it never creates a dependency.
    always_comb begin
        match_ex  = (i_rd_id_ex != NB_ADDR'(REG_ZERO)) &&
                    ((i_rd_id_ex == i_rs_id) || (i_uses_rt_id && (i_rd_id_ex == i_rt_id)));
        match_mem = (i_rd_ex_m != NB_ADDR'(REG_ZERO)) &&
                    ((i_rd_ex_m == i_rs_id) || (i_uses_rt_id && (i_rd_ex_m == i_rt_id)));
    end

    always_comb begin
        o_stall = (i_memRead_id_ex && match_ex)
               || (i_branch_id && i_regWrite_id_ex && match_ex)
               || (i_branch_id && i_memRead_ex_m && match_mem);
    end

endmodule

// File: rtl/hazard_unit_id.sv
// ID-stage stall/flush/halt controller with pipeline drain FSM and stall-cycle counter.
module hazard_unit_id
    import hazard_unit_id_pkg::*;
#(
    parameter int unsigned NB_ADDR  = 5,
    parameter int unsigned NB_CNT   = 32,
    parameter int unsigned NB_DRAIN = DEF_NB_DRAIN
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [NB_ADDR-1:0] i_rs_id,
    input  logic [NB_ADDR-1:0] i_rt_id,
    input  logic               i_uses_rt_id,
    input  logic               i_branch_id,
    input  logic               i_jump_id,
    input  logic               i_branch_taken,
    input  logic               i_halt_id,
    input  logic [NB_ADDR-1:0] i_rd_id_ex,
    input  logic               i_regWrite_id_ex,
    input  logic               i_memRead_id_ex,
    input  logic [NB_ADDR-1:0] i_rd_ex_m,
    input  logic               i_memRead_ex_m,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_id_ex_bubble,
    output logic               o_if_id_flush,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_stall_count
);

    localparam int unsigned NB_DC = (NB_DRAIN > 1) ? $clog2(NB_DRAIN) : 1;

    hz_state_t        state;
    logic [NB_DC-1:0] drain_cnt;
    logic             stall;

    hazard_detect_id #(
        .NB_ADDR (NB_ADDR)
    ) u_detect (
        .i_rs_id          (i_rs_id),
        .i_rt_id          (i_rt_id),
        .i_uses_rt_id     (i_uses_rt_id),
        .i_branch_id      (i_branch_id),
        .i_rd_id_ex       (i_rd_id_ex),
        .i_regWrite_id_ex (i_regWrite_id_ex),
        .i_memRead_id_ex  (i_memRead_id_ex),
        .i_rd_ex_m        (i_rd_ex_m),
        .i_memRead_ex_m   (i_memRead_ex_m),
        .o_stall          (stall)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            o_stall_count <= '0;
        end else if (i_enable) begin
            case (state)
                ST_RUN: begin
                    // Stall outranks halt so a HALT waits until its operands are clear.
                    if (stall) begin
                        if (o_stall_count != '1)
                            o_stall_count <= o_stall_count + NB_CNT'(1);
                    end else if (i_halt_id) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + NB_DC'(1);
                    if (drain_cnt == NB_DC'(NB_DRAIN - 1))
                        state <= ST_HALTED;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

    // Controls are forced low during reset even though the state is already RUN.
    always_comb begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        if (!i_rst && i_enable) begin
            case (state)
                ST_RUN: begin
                    if (stall || i_halt_id) begin
                        o_id_ex_bubble = 1'b1;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                        o_if_id_flush = i_jump_id || (i_branch_id && i_branch_taken);
                    end
                end
                ST_DRAIN: o_id_ex_bubble = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_halted = (state == ST_HALTED);
    end

endmodule

// File: doc/hazard_unit_id.md
Name: hazard_unit_ID

Overview:
Stall/flush/halt controller for the ID stage, paired with forwarding_unit_ID in the control-hazard unit. Detects load-use and branch-operand hazards that forwarding cannot cover and freezes PC and IF/ID while bubbling ID/EX. Issues IF/ID flush on taken branches and jumps. Drains the pipeline on a HALT instruction and keeps a saturating stall-cycle counter for the debug unit.

Parameters:
NB_ADDR, 5, register address width
NB_CNT, 32, stall counter width
NB_DRAIN, 3, cycles needed to retire EX/MEM/WB after HALT reaches ID

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_enable  input  1  debug step enable; 0 freezes the pipeline and this block
i_rs_id  input  NB_ADDR  rs of instruction in ID
i_rt_id  input  NB_ADDR  rt of instruction in ID
i_uses_rt_id  input  1  ID instruction reads rt
i_branch_id  input  1  ID instruction resolves in ID (beq/bne/jr/jalr)
i_jump_id  input  1  unconditional j/jal in ID
i_branch_taken  input  1  ID comparator result
i_halt_id  input  1  HALT opcode in ID
i_rd_id_ex  input  NB_ADDR  destination of instruction in EX
i_regWrite_id_ex  input  1  EX instruction writes register
i_memRead_id_ex  input  1  EX instruction is a load
i_rd_ex_m  input  NB_ADDR  destination of instruction in MEM
i_memRead_ex_m  input  1  MEM instruction is a load
o_pc_write  output  1  PC update enable
o_if_id_write  output  1  IF/ID register write enable
o_id_ex_bubble  output  1  zero control fields into ID/EX
o_if_id_flush  output  1  clear IF/ID
o_halted  output  1  pipeline drained and stopped
o_stall_count  output  NB_CNT  total stall cycles since reset

Behaviour:
- Reset (async, i_rst=1): state RUN, drain counter 0, o_stall_count 0. o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush and o_halted all 0 while reset is asserted.
- Match definitions (rd==0 never matches):
  - mA(rd) = rd==i_rs_id.
  - mB(rd) = i_uses_rt_id && rd==i_rt_id.
  - M(rd) = mA(rd) || mB(rd).
- stall is 1 if any of these holds:
  - load-use: i_memRead_id_ex && M(i_rd_id_ex)
  - branch after ALU op: i_branch_id && i_regWrite_id_ex && M(i_rd_id_ex)
  - branch after load in MEM: i_branch_id && i_memRead_ex_m && M(i_rd_ex_m)
  - A load followed by a branch therefore stalls 2 cycles. The ALU case stalls 1 cycle; forwarding_unit_ID then supplies the value from EX/MEM.
- FSM states: RUN, DRAIN, HALTED. Outputs are combinational from state and inputs. State, counters and outputs are evaluated by this priority:
  1. i_enable=0: all four control outputs 0, state and counters hold.
  2. HALTED: controls 0, o_halted=1. The block stays here until reset.
  3. DRAIN: pc_write=0, if_id_write=0, bubble=1, flush=0. The drain counter increments each cycle. At NB_DRAIN-1 the next state is HALTED.
  4. RUN with stall=1: pc_write=0, if_id_write=0, bubble=1, flush=0. o_stall_count increments, saturating at all-ones.
  5. RUN with i_halt_id=1: same outputs as the DRAIN row. Next state DRAIN with counter cleared; the HALT itself is bubbled.
  6. RUN otherwise: pc_write=1, if_id_write=1, bubble=0, flush=(i_jump_id || (i_branch_id && i_branch_taken)).
- A stall always suppresses flush. The branch is re-evaluated after the stall resolves.
- Simultaneous stall and halt: the stall wins; the halt is taken once operands are clear.
- Reset asserted mid-DRAIN or in HALTED returns the FSM to RUN immediately.
- o_halted is registered: it rises in the first cycle the state is HALTED, NB_DRAIN+1 cycles after HALT is seen in ID with i_enable=1 throughout.

Decomposition:
- Shared package holds:
  - the state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
  - the zero-register constant
  - the default NB_DRAIN
- One natural sub-module, hazard_detect_ID: purely combinational, producing stall from the match rules. The top holds the FSM, the drain counter and o_stall_count.

Test Plan:
- Load-use: EX=lw rd=5 (memRead=1); ID rs=5 -> exactly 1 cycle with pc_write=0, bubble=1, stall_count=1; next cycle pc_write=1.
- Branch after lw: EX=lw rd=8, ID beq rs=8 -> 2 consecutive stall cycles, flush=0 throughout. Third cycle with taken=1 gives flush=1; stall_count=2.
- Zero/unused operands:
  - EX=lw rd=0, ID rs=0 -> no stall.
  - EX=lw rd=3, ID rt=3 with uses_rt=0 -> no stall.
- HALT: i_halt_id=1 in RUN -> bubble=1 for 1+NB_DRAIN cycles (4), then o_halted=1 and controls 0. Further instructions are ignored.
- Freeze: i_enable=0 during a load-use stall -> all controls 0, stall_count unchanged. Re-enable -> stall completes normally.
- Reset mid-DRAIN (cycle 2) -> all outputs 0 during reset, o_halted=0, stall_count=0. After release, RUN with pc_write=1.
